// File: rtl/io_port_unit.sv
// Buffered CPU I/O ports: NUM_IN first-word-fall-through input FIFOs and NUM_OUT valid/ack output registers, zero-latency bus read.
// stall holds the control step on an empty-FIFO read or an unacked output write; `IO_DROP_CNT_EN adds per-channel drop counters.

module io_port_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Callers only push when not full and only pop when not empty.
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!i_push && i_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

module io_port_unit #(
  parameter int DATA_W     = 32,
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SEL_W      = 2
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic                      InPortout,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [DATA_W-1:0]         BusMuxIn_InPort,
  input  logic [DATA_W-1:0]         BusMuxOut,
  input  logic                      Out_portIn,
  input  logic [SEL_W-1:0]          out_sel,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ack,
`ifdef IO_DROP_CNT_EN
  output logic [NUM_IN*8-1:0]       drop_cnt,
`endif
  output logic                      stall
);
  logic [DATA_W-1:0]  w_head [NUM_IN];
  logic [NUM_IN-1:0]  w_full;
  logic [NUM_IN-1:0]  w_empty;
  logic [NUM_IN-1:0]  w_push;
  logic [NUM_IN-1:0]  w_pop;
  logic               w_rd_stall;
  logic               w_wr_stall;
  logic [NUM_OUT-1:0] w_accept;
  logic [DATA_W-1:0]  r_out_data [NUM_OUT];
  logic [NUM_OUT-1:0] r_out_valid;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    assign in_ready[k] = clear && !w_full[k];
    assign w_push[k]   = in_valid[k] && in_ready[k];
    assign w_pop[k]    = InPortout && (in_sel == SEL_W'(k)) && !w_empty[k];

    io_port_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .clear   (clear),
      .i_push  (w_push[k]),
      .i_pop   (w_pop[k]),
      .i_din   (in_data[k*DATA_W +: DATA_W]),
      .o_head  (w_head[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k])
    );

`ifdef IO_DROP_CNT_EN
    logic [7:0] r_drop;
    always_ff @(posedge clock) begin
      if (!clear)                                         r_drop <= '0;
      else if (in_valid[k] && !in_ready[k] && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
    assign drop_cnt[k*8 +: 8] = r_drop;
`endif
  end

  // An out-of-range select matches no channel: bus reads 0 and nothing stalls.
  always_comb begin
    BusMuxIn_InPort = '0;
    w_rd_stall      = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        if (w_empty[k]) w_rd_stall = InPortout;
        else            BusMuxIn_InPort = w_head[k];
      end
    end
  end

  always_comb begin
    w_wr_stall = 1'b0;
    w_accept   = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (Out_portIn && (out_sel == SEL_W'(j))) begin
        w_accept[j] = !r_out_valid[j] || out_ack[j];
        w_wr_stall  = r_out_valid[j] && !out_ack[j];
      end
    end
  end

  assign stall = w_rd_stall || w_wr_stall;

  // A write in the ack cycle takes priority, so valid stays set for the new word.
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_out_valid <= '0;
      for (int j = 0; j < NUM_OUT; j++) r_out_data[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (w_accept[j]) begin
          r_out_data[j]  <= BusMuxOut;
          r_out_valid[j] <= 1'b1;
        end else if (out_ack[j] && r_out_valid[j]) begin
          r_out_valid[j] <= 1'b0;
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign out_data[j*DATA_W +: DATA_W] = r_out_data[j];
  end
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_io_port_unit.sv
// Testbench for io_port_unit: vector table for bus/write/reset behaviour, queue scoreboard for the input FIFOs.

module tb_io_port_unit;
  logic        clock = 1'b0;
  logic        clear;
  logic [63:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic        InPortout;
  logic [1:0]  in_sel;
  logic [31:0] BusMuxIn_InPort;
  logic [31:0] BusMuxOut;
  logic        Out_portIn;
  logic [1:0]  out_sel;
  logic [63:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ack;
  logic        stall;
`ifdef IO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sbq0 [$];
  logic [31:0] sbq1 [$];

  io_port_unit dut (
    .clock           (clock),
    .clear           (clear),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .InPortout       (InPortout),
    .in_sel          (in_sel),
    .BusMuxIn_InPort (BusMuxIn_InPort),
    .BusMuxOut       (BusMuxOut),
    .Out_portIn      (Out_portIn),
    .out_sel         (out_sel),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ack         (out_ack),
`ifdef IO_DROP_CNT_EN
    .drop_cnt        (drop_cnt),
`endif
    .stall           (stall)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        clr;
    logic [1:0]  iv;
    logic [31:0] d0;
    logic        rd;
    logic [1:0]  isel;
    logic        wr;
    logic [1:0]  osel;
    logic [31:0] bus;
    logic [1:0]  ack;
    logic [31:0] ebus;
    logic        estall;
    logic [1:0]  erdy;
    logic [1:0]  eov;
    logic [31:0] eod0;
    logic [31:0] eod1;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of FIFO traffic and checks against the queue model.
  task automatic sb_step(input logic [1:0] iv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic rd, input logic [1:0] isel);
    logic [1:0]  erdy;
    logic [31:0] ebus;
    logic        estall;
    clear = 1'b1; Out_portIn = 1'b0; out_ack = 2'b00; BusMuxOut = '0;
    in_valid = iv; in_data = {d1, d0}; InPortout = rd; in_sel = isel;
    #1;
    erdy   = {sbq1.size() < 4, sbq0.size() < 4};
    ebus   = 32'h0;
    estall = 1'b0;
    if (isel == 2'd0) begin
      if (sbq0.size() > 0) ebus = sbq0[0]; else estall = rd;
    end else if (isel == 2'd1) begin
      if (sbq1.size() > 0) ebus = sbq1[0]; else estall = rd;
    end
    chk("sb_in_ready", {62'b0, in_ready}, {62'b0, erdy});
    chk("sb_bus", {32'b0, BusMuxIn_InPort}, {32'b0, ebus});
    chk("sb_stall", {63'b0, stall}, {63'b0, estall});
    if (rd && isel == 2'd0 && sbq0.size() > 0) void'(sbq0.pop_front());
    if (rd && isel == 2'd1 && sbq1.size() > 0) void'(sbq1.pop_front());
    if (iv[0] && erdy[0]) sbq0.push_back(d0);
    if (iv[1] && erdy[1]) sbq1.push_back(d1);
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic vec_t mk(logic clr, logic [1:0] iv, logic [31:0] d0, logic rd, logic [1:0] isel,
                              logic wr, logic [1:0] osel, logic [31:0] bus, logic [1:0] ack,
                              logic [31:0] ebus, logic estall, logic [1:0] erdy, logic [1:0] eov,
                              logic [31:0] eod0, logic [31:0] eod1);
    return '{clr, iv, d0, rd, isel, wr, osel, bus, ack, ebus, estall, erdy, eov, eod0, eod1};
  endfunction

  initial begin
    vt[0]  = mk(1, 2'b01, 32'hA1,   0, 0, 0, 0, 32'h0,    2'b00, 32'h0,  0, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[1]  = mk(1, 2'b01, 32'hA2,   1, 0, 0, 0, 32'h0,    2'b00, 32'hA1, 0, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[2]  = mk(1, 2'b00, 32'h0,    1, 0, 0, 0, 32'h0,    2'b00, 32'hA2, 0, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[3]  = mk(1, 2'b00, 32'h0,    1, 0, 0, 0, 32'h0,    2'b00, 32'h0,  1, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[4]  = mk(1, 2'b01, 32'h55,   1, 0, 0, 0, 32'h0,    2'b00, 32'h0,  1, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[5]  = mk(1, 2'b00, 32'h0,    1, 0, 0, 0, 32'h0,    2'b00, 32'h55, 0, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[6]  = mk(1, 2'b00, 32'h0,    1, 2, 0, 0, 32'h0,    2'b00, 32'h0,  0, 2'b11, 2'b00, 32'h0,    32'h0);
    vt[7]  = mk(1, 2'b00, 32'h0,    0, 0, 1, 1, 32'h1234, 2'b00, 32'h0,  0, 2'b11, 2'b10, 32'h0,    32'h1234);
    vt[8]  = mk(1, 2'b00, 32'h0,    0, 0, 1, 1, 32'h5678, 2'b00, 32'h0,  1, 2'b11, 2'b10, 32'h0,    32'h1234);
    vt[9]  = mk(1, 2'b00, 32'h0,    0, 0, 1, 1, 32'h5678, 2'b10, 32'h0,  0, 2'b11, 2'b10, 32'h0,    32'h5678);
    vt[10] = mk(1, 2'b00, 32'h0,    0, 0, 0, 0, 32'h0,    2'b10, 32'h0,  0, 2'b11, 2'b00, 32'h0,    32'h5678);
    vt[11] = mk(1, 2'b00, 32'h0,    0, 0, 0, 0, 32'h0,    2'b10, 32'h0,  0, 2'b11, 2'b00, 32'h0,    32'h5678);
    vt[12] = mk(1, 2'b00, 32'h0,    0, 0, 1, 2, 32'h9999, 2'b00, 32'h0,  0, 2'b11, 2'b00, 32'h0,    32'h5678);
    vt[13] = mk(1, 2'b00, 32'h0,    1, 0, 1, 0, 32'hABCD, 2'b00, 32'h0,  1, 2'b11, 2'b01, 32'hABCD, 32'h5678);
    vt[14] = mk(1, 2'b00, 32'h0,    0, 0, 1, 0, 32'h1111, 2'b00, 32'h0,  1, 2'b11, 2'b01, 32'hABCD, 32'h5678);
    vt[15] = mk(1, 2'b01, 32'h01,   0, 0, 0, 0, 32'h0,    2'b00, 32'h0,  0, 2'b11, 2'b01, 32'hABCD, 32'h5678);
    vt[16] = mk(1, 2'b01, 32'h02,   0, 0, 0, 0, 32'h0,    2'b00, 32'h01, 0, 2'b11, 2'b01, 32'hABCD, 32'h5678);
    vt[17] = mk(1, 2'b01, 32'h03,   0, 0, 0, 0, 32'h0,    2'b00, 32'h01, 0, 2'b11, 2'b01, 32'hABCD, 32'h5678);
    vt[18] = mk(0, 2'b01, 32'h04,   0, 0, 0, 0, 32'h0,    2'b00, 32'h01, 0, 2'b00, 2'b00, 32'h0,    32'h0);
    vt[19] = mk(1, 2'b00, 32'h0,    1, 0, 0, 0, 32'h0,    2'b00, 32'h0,  1, 2'b11, 2'b00, 32'h0,    32'h0);

    clear = 1'b0; in_data = '0; in_valid = '0; InPortout = 1'b0; in_sel = '0;
    BusMuxOut = '0; Out_portIn = 1'b0; out_sel = '0; out_ack = '0;

    // Reset
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_in_ready", {62'b0, in_ready}, 64'h0);
    @(negedge clock);
    clear = 1'b1;
    #1;
    chk("rst_in_ready_after", {62'b0, in_ready}, 64'h3);
    chk("rst_out_valid", {62'b0, out_valid}, 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_bus", {32'b0, BusMuxIn_InPort}, 64'h0);
    chk("rst_stall", {63'b0, stall}, 64'h0);
    @(negedge clock);

    // Vector table: comb outputs before the edge, registered outputs after it
    for (int i = 0; i < 20; i++) begin
      clear = vt[i].clr; in_valid = vt[i].iv; in_data = {32'h0, vt[i].d0};
      InPortout = vt[i].rd; in_sel = vt[i].isel; Out_portIn = vt[i].wr;
      out_sel = vt[i].osel; BusMuxOut = vt[i].bus; out_ack = vt[i].ack;
      #1;
      chk($sformatf("v%0d_bus", i), {32'b0, BusMuxIn_InPort}, {32'b0, vt[i].ebus});
      chk($sformatf("v%0d_stall", i), {63'b0, stall}, {63'b0, vt[i].estall});
      chk($sformatf("v%0d_in_ready", i), {62'b0, in_ready}, {62'b0, vt[i].erdy});
      @(posedge clock); #1;
      chk($sformatf("v%0d_out_valid", i), {62'b0, out_valid}, {62'b0, vt[i].eov});
      chk($sformatf("v%0d_out_data", i), out_data, {vt[i].eod1, vt[i].eod0});
      @(negedge clock);
    end

    // Channel 1 overflow and pointer wrap
    for (int i = 0; i < 5; i++) sb_step(2'b10, 32'h0, 32'hB0 + i, 1'b0, 2'd1);
    sb_step(2'b10, 32'h0, 32'hB4, 1'b1, 2'd1);
    sb_step(2'b10, 32'h0, 32'hB4, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) sb_step(2'b00, 32'h0, 32'h0, 1'b1, 2'd1);

    // Random traffic on both channels
    for (int i = 0; i < 300; i++)
      sb_step(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)));

`ifdef IO_DROP_CNT_EN
    clear = 1'b0;
    @(posedge clock); @(negedge clock);
    sbq0.delete(); sbq1.delete();
    for (int i = 0; i < 4; i++) sb_step(2'b01, 32'hC0 + i, 32'h0, 1'b0, 2'd0);
    for (int i = 0; i < 300; i++) sb_step(2'b01, 32'hCC, 32'h0, 1'b0, 2'd0);
    #1;
    chk("drop_cnt_ch0", {56'b0, drop_cnt[7:0]}, 64'd255);
    chk("drop_cnt_ch1", {56'b0, drop_cnt[15:8]}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
